// File: rtl/rst_release_seq_if.sv
// Handshake bundle for the reset-release sequencer: request/hold inputs, per-domain SETB outputs and status.
interface rst_release_seq_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   SOFT_REQ;
  logic                   HOLD;
  logic [NUM_DOMAINS-1:0] SETB_OUT;
  logic                   DONE;
  logic                   BUSY;

  modport master (output SOFT_REQ, HOLD, input SETB_OUT, DONE, BUSY);
  modport slave  (input SOFT_REQ, HOLD, output SETB_OUT, DONE, BUSY);
endinterface

// File: rtl/rst_release_seq.sv
// Reset-release sequencer: asserts all SETB domains on RST, then releases them one by one on posedge CLK.
// Optional macro RST_RELEASE_SEQ_REQ_FILTER_EN adds a 3-sample filter on SOFT_REQ.
module rst_release_seq #(
  parameter int NUM_DOMAINS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 8,
  parameter int MIN_ASSERT  = 4
) (
  input logic               CLK,
  input logic               RST,
  rst_release_seq_if.slave  io
);

  localparam int CNT_MAX = (GAP_CYCLES > MIN_ASSERT) ? GAP_CYCLES : MIN_ASSERT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_RELEASE,
    S_DONE,
    S_ASSERT
  } state_t;

  state_t                 r_state, w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nx;
  logic [IDX_W-1:0]       r_idx, w_idx_nx;
  logic [NUM_DOMAINS-1:0] r_setb, w_setb_nx;
  logic                   r_done, w_done_nx;
  logic                   w_rst_ok_nx;
  logic                   w_req_accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  // rst_ok rises on this edge when the next-to-last stage is already 1, so WAIT can leave on T0 itself.
  assign w_rst_ok_nx = r_sync[SYNC_STAGES-2];

`ifdef RST_RELEASE_SEQ_REQ_FILTER_EN
  logic [1:0] r_req_cnt, w_req_cnt_nx;

  always_comb begin
    w_req_cnt_nx = '0;
    w_req_accept = 1'b0;
    if (r_state == S_DONE && io.SOFT_REQ) begin
      if (r_req_cnt == 2'd2) w_req_accept = 1'b1;
      else                   w_req_cnt_nx = r_req_cnt + 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_req_cnt <= '0;
    else     r_req_cnt <= w_req_cnt_nx;
  end
`else
  assign w_req_accept = io.SOFT_REQ;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_setb_nx  = r_setb;
    w_done_nx  = r_done;
    case (r_state)
      S_WAIT: begin
        if (w_rst_ok_nx) begin
          w_state_nx = S_RELEASE;
          w_cnt_nx   = '0;
        end
      end
      S_RELEASE: begin
        if (!io.HOLD) begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_nx         = '0;
            w_setb_nx[r_idx] = 1'b1;
            if (r_idx == IDX_LAST) begin
              w_state_nx = S_DONE;
              w_done_nx  = 1'b1;
              w_idx_nx   = '0;
            end else begin
              w_idx_nx = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (w_req_accept) begin
          w_state_nx = S_ASSERT;
          w_setb_nx  = '0;
          w_done_nx  = 1'b0;
          w_cnt_nx   = '0;
        end
      end
      S_ASSERT: begin
        // Final assert edge doubles as the new T0 for the release schedule.
        if (r_cnt == ASSERT_LAST) begin
          w_state_nx = S_RELEASE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_setb  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_setb  <= w_setb_nx;
      r_done  <= w_done_nx;
    end
  end

  assign io.SETB_OUT = r_setb;
  assign io.DONE     = r_done;
  assign io.BUSY     = ~r_done;

endmodule

// File: tb/tb_rst_release_seq.sv
// Randomised scoreboard bench for rst_release_seq; set RST_RELEASE_SEQ_REQ_FILTER_EN to cover the filtered build.
`timescale 1ns/1ps
module tb_rst_release_seq;
  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int GAP  = 8;
  localparam int MINA = 4;
`ifdef RST_RELEASE_SEQ_REQ_FILTER_EN
  localparam int FILT = 3;
`else
  localparam int FILT = 1;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rst_release_seq_if #(.NUM_DOMAINS(N)) io ();

  rst_release_seq #(
    .NUM_DOMAINS(N),
    .SYNC_STAGES(SYNC),
    .GAP_CYCLES (GAP),
    .MIN_ASSERT (MINA)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .io (io)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] setb;
    logic         done;
  } ev_t;

  ev_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: domain i is released once (i+1)*GAP non-held edges have elapsed since T0.
  typedef enum {M_SYNC, M_REL, M_DONE, M_ASSERT} mphase_t;
  mphase_t      m_phase;
  int           m_edges, m_prog, m_fcnt, m_acnt, m_rel;
  logic [N-1:0] m_setb, m_nsetb;
  logic         m_done, m_ndone;
  ev_t          m_ev;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase = M_SYNC;
      m_edges = 0;
      m_prog  = 0;
      m_fcnt  = 0;
      m_acnt  = 0;
      m_setb  = '0;
      m_done  = 1'b0;
      sb_q.delete();
    end else begin
      m_nsetb = m_setb;
      m_ndone = m_done;
      case (m_phase)
        M_SYNC: begin
          m_edges++;
          if (m_edges == SYNC) begin
            m_phase = M_REL;
            m_prog  = 0;
          end
        end
        M_REL: begin
          if (!io.HOLD) m_prog++;
          m_rel = m_prog / GAP;
          if (m_rel > N) m_rel = N;
          m_nsetb = N'((64'd1 << m_rel) - 64'd1);
          if (m_rel == N) begin
            m_phase = M_DONE;
            m_ndone = 1'b1;
          end
        end
        M_DONE: begin
          if (io.SOFT_REQ) begin
            m_fcnt++;
            if (m_fcnt == FILT) begin
              m_fcnt  = 0;
              m_nsetb = '0;
              m_ndone = 1'b0;
              m_phase = M_ASSERT;
              m_acnt  = 0;
            end
          end else begin
            m_fcnt = 0;
          end
        end
        M_ASSERT: begin
          m_acnt++;
          if (m_acnt == MINA) begin
            m_phase = M_REL;
            m_prog  = 0;
          end
        end
        default: m_phase = M_SYNC;
      endcase
      if (m_nsetb !== m_setb || m_ndone !== m_done) begin
        m_ev.cyc  = cyc;
        m_ev.setb = m_nsetb;
        m_ev.done = m_ndone;
        sb_q.push_back(m_ev);
      end
      m_setb = m_nsetb;
      m_done = m_ndone;
    end
  end

  // Monitor: every observed output change pops one expected event.
  logic [N-1:0] mon_setb = '0;
  logic         mon_done = 1'b0;
  ev_t          mon_e;

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      mon_setb = '0;
      mon_done = 1'b0;
    end else begin
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc - 1) begin
        mon_e = sb_q.pop_front();
        check("missed_event_cycle", cyc - 1, mon_e.cyc);
      end
      if (io.SETB_OUT !== mon_setb || io.DONE !== mon_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_change", {io.DONE, io.SETB_OUT}, {mon_done, mon_setb});
        end else begin
          mon_e = sb_q.pop_front();
          check("event_cycle", cyc - 1, mon_e.cyc);
          check("setb_out", io.SETB_OUT, mon_e.setb);
          check("done", io.DONE, mon_e.done);
          check("busy", io.BUSY, !mon_e.done);
        end
        mon_setb = io.SETB_OUT;
        mon_done = io.DONE;
      end
    end
  end

  task automatic drive_reset(int hold_cycles);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("rst_setb", io.SETB_OUT, 0);
    check("rst_done", io.DONE, 0);
    check("rst_busy", io.BUSY, 1);
    repeat (hold_cycles) @(negedge CLK);
    #2;
    RST = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (io.DONE !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("done_timeout", io.DONE, 1);
  endtask

  task automatic wait_setb(logic [N-1:0] v, int budget);
    int n = 0;
    while (io.SETB_OUT !== v && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("setb_wait_timeout", io.SETB_OUT, v);
  endtask

  task automatic soft_pulse();
    @(negedge CLK);
    io.SOFT_REQ = 1'b1;
    repeat (FILT) @(negedge CLK);
    io.SOFT_REQ = 1'b0;
  endtask

  initial begin
    logic [5:0] pat;
    io.SOFT_REQ = 1'b0;
    io.HOLD     = 1'b0;

    // Power-on sequence and a full soft re-run.
    drive_reset(3);
    wait_done(60);
    soft_pulse();
    wait_done(80);

    // Reset pulse in the middle of a release sequence.
    drive_reset(2);
    wait_setb(N'(4'b0011), 60);
    drive_reset(1);
    wait_done(60);

    // SOFT_REQ during RELEASE is ignored (sampled at E5).
    drive_reset(3);
    repeat (4) @(negedge CLK);
    io.SOFT_REQ = 1'b1;
    @(negedge CLK);
    io.SOFT_REQ = 1'b0;
    wait_done(60);

    // HOLD for 5 cycles just after domain 0 is released.
    drive_reset(2);
    wait_setb(N'(4'b0001), 60);
    io.HOLD = 1'b1;
    repeat (5) @(negedge CLK);
    io.HOLD = 1'b0;
    wait_done(60);

    // Request pattern 1,1,0,1,1,1 on consecutive edges while DONE.
    pat = 6'b111011;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      io.SOFT_REQ = pat[i];
    end
    @(negedge CLK);
    io.SOFT_REQ = 1'b0;
    wait_done(80);

    // Randomised HOLD / SOFT_REQ / RST traffic.
    for (int it = 0; it < 8; it++) begin
      int len;
      len = int'($urandom_range(20, 70));
      for (int c = 0; c < len; c++) begin
        @(negedge CLK);
        io.HOLD     = ($urandom_range(0, 3) == 0);
        io.SOFT_REQ = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 59) == 0) drive_reset(int'($urandom_range(1, 3)));
      end
      @(negedge CLK);
      io.HOLD     = 1'b0;
      io.SOFT_REQ = 1'b0;
      wait_done(200);
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rst_release_seq.md
Name: rst_release_seq

Overview:
- Reset-release sequencer that generates the active-low SETB/RSTB nets for banks of negedge-triggered async-set/reset flops (DFFNAS/DFFNAR family).
- Sits directly upstream of those flops: asserts all domains asynchronously, then releases them one at a time, synchronised and spaced apart.
- Release edges come from posedge CLK. Downstream negedge flops therefore get half a cycle of recovery/removal margin.

Parameters:
NUM_DOMAINS, 4, number of independent SETB outputs (1..16)
SYNC_STAGES, 2, reset-deassert synchroniser depth (>=2)
GAP_CYCLES, 8, CLK cycles between successive domain releases (>=1)
MIN_ASSERT, 4, CLK cycles all domains are held asserted after a soft request (>=1)

Ports:
CLK  input  1  clock; all state on posedge
RST  input  1  asynchronous, active-high reset
SOFT_REQ  input  1  synchronous request to re-run the full assert/release sequence
HOLD  input  1  freezes the release gap counter while high
SETB_OUT  output  NUM_DOMAINS  active-low set/reset per domain; bit i drives domain i
DONE  output  1  high once all domains are released
BUSY  output  1  equals ~DONE

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- RST=1 acts immediately, with no clock needed:
  - SETB_OUT=0 (all domains asserted), DONE=0, BUSY=1.
  - Synchroniser chain cleared to 0; gap counter=0; domain index=0; state=WAIT.
- Synchroniser:
  - SYNC_STAGES flops shift in 1 after RST falls; rst_ok = last stage.
  - rst_ok rises on the SYNC_STAGES-th posedge after RST falls. Call that edge T0.
- States:
  - WAIT: SETB_OUT=0. Leaves when rst_ok=1, loading the gap counter at T0 → RELEASE.
  - RELEASE:
    - Counter increments each posedge with HOLD=0; holds when HOLD=1.
    - When it reaches GAP_CYCLES: SETB_OUT[idx] goes 1 on that edge, counter clears, idx increments.
    - Releasing idx=NUM_DOMAINS-1 → DONE state.
    - Without HOLD, SETB_OUT[i] rises exactly at T0+(i+1)*GAP_CYCLES.
  - DONE: SETB_OUT all 1, DONE=1.
    - SOFT_REQ sampled 1 → on that same edge SETB_OUT=0, DONE=0, counter cleared → ASSERT.
  - ASSERT: counts MIN_ASSERT posedges with SETB_OUT=0 (HOLD ignored).
    - Final edge serves as new T0 → RELEASE.
- SOFT_REQ outside DONE is ignored; it is neither queued nor counted.
- Released bits never return to 0 except through RST or an accepted SOFT_REQ. Outputs are glitch-free, driven straight from flops.
- RST during any state, mid-release included: immediate async return to the reset values above. The sequence restarts from domain 0.
- SETB_OUT changes only on posedge CLK or async RST. It never changes on negedge.
- Counter width is $clog2(max(GAP_CYCLES,MIN_ASSERT)+1). No wrap: the counter clears on match.

Optional Feature:
Macro RST_RELEASE_SEQ_REQ_FILTER_EN.
- Defined: SOFT_REQ passes a 3-sample filter. It is accepted only on the 3rd consecutive posedge sampling SOFT_REQ=1 while in DONE.
  - A 0 sample resets the filter.
  - The filter also clears on RST and on acceptance.
- Undefined: SOFT_REQ is accepted on the first posedge sampling 1 in DONE. No filter flops exist.

Test Plan:
- Defaults, RST high 3 cycles then low between edges (E1 = first posedge after fall) → rst_ok at E2; SETB_OUT becomes 4'b0001 @E10, 0011 @E18, 0111 @E26, 1111 @E34; DONE=1 and BUSY=0 @E34.
- After DONE, SOFT_REQ=1 for one cycle sampled @S (filter undefined) → SETB_OUT=0 @S, DONE=0; SETB_OUT[0]=1 @S+12, SETB_OUT=1111 @S+36.
- Mid-sequence, SETB_OUT=0011, RST pulsed between edges → SETB_OUT=0 and DONE=0 before the next edge; restart timing identical to scenario 1.
- HOLD=1 for 5 cycles starting after SETB_OUT[0] release → SETB_OUT[1] rises 5 cycles late (E23 instead of E18), SETB_OUT[3] @E39.
- SOFT_REQ=1 at E5 during RELEASE → ignored; release timing unchanged vs scenario 1.
- Filter defined, in DONE: SOFT_REQ 1,1,0,1,1,1 on consecutive edges → no action on the first pair; assertion (SETB_OUT=0) on the 6th edge only.
